// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-stage registers: occupancy-state
// encodings, the default Tnew width and the saturating Tnew decrement.
package pipe_pkg;

  // Encodings equal the number of held entries, so the state doubles as Occupancy.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam int unsigned TNEW_W_DEFAULT = 3;
  localparam int unsigned TNEW_MAX_W     = 8;

  // Callers zero-extend into TNEW_MAX_W bits and truncate the result back.
  function automatic logic [TNEW_MAX_W-1:0] sat_dec(input logic [TNEW_MAX_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_MAX_W'(1);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline-stage entry: valid bit, payload, destination register and a
// self-decrementing Tnew. Fields read as zero whenever the slot is empty.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 96,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned TNEW_W    = TNEW_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 clear,
  input  logic                 hold_dec,
  input  logic [PAYLOAD_W-1:0] d_payload,
  input  logic [ADDR_W-1:0]    d_reg_addr,
  input  logic [TNEW_W-1:0]    d_tnew,
  output logic [PAYLOAD_W-1:0] q_payload,
  output logic [ADDR_W-1:0]    q_reg_addr,
  output logic [TNEW_W-1:0]    q_tnew
);

  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [ADDR_W-1:0]    reg_addr_q, reg_addr_d;
  logic [TNEW_W-1:0]    tnew_q, tnew_d;

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return TNEW_W'(sat_dec(TNEW_MAX_W'(t)));
  endfunction

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    valid_d    = valid_q;
    payload_d  = payload_q;
    reg_addr_d = reg_addr_q;
    tnew_d     = tnew_q;
    if (clear) begin
      valid_d    = 1'b0;
      payload_d  = '0;
      reg_addr_d = '0;
      tnew_d     = '0;
    end else if (load) begin
      valid_d    = 1'b1;
      payload_d  = d_payload;
      reg_addr_d = d_reg_addr;
      tnew_d     = tnew_dec(d_tnew);
    end else if (hold_dec) begin
      tnew_d     = tnew_dec(tnew_q);
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: a single entry register, not a memory array, so every field is reset to keep bubbles at zero.
      valid_q    <= 1'b0;
      payload_q  <= '0;
      reg_addr_q <= '0;
      tnew_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      payload_q  <= payload_d;
      reg_addr_q <= reg_addr_d;
      tnew_q     <= tnew_d;
    end
  end

  assign q_payload  = valid_q ? payload_q  : '0;
  assign q_reg_addr = valid_q ? reg_addr_q : '0;
  assign q_tnew     = valid_q ? tnew_q     : '0;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register with valid/ready handshake, optional skid
// entry (registered In_Ready) and self-decrementing Tnew for hazard logic.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 96,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned TNEW_W    = TNEW_W_DEFAULT,
  parameter bit          SKID      = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Flush,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [PAYLOAD_W-1:0] In_Payload,
  input  logic [ADDR_W-1:0]    In_RegAddr,
  input  logic [TNEW_W-1:0]    In_Tnew,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [PAYLOAD_W-1:0] Out_Payload,
  output logic [ADDR_W-1:0]    Out_RegAddr,
  output logic [TNEW_W-1:0]    Out_Tnew,
  output logic [1:0]           Occupancy
);

  logic [1:0]           state_q, state_d;
  logic                 out_valid, in_ready, push, pop;
  logic                 head_load, head_clear, head_hold, head_from_skid;
  logic                 skid_load, skid_clear, skid_hold;
  logic [PAYLOAD_W-1:0] head_payload, skid_payload, head_d_payload;
  logic [ADDR_W-1:0]    head_reg_addr, skid_reg_addr, head_d_reg_addr;
  logic [TNEW_W-1:0]    head_tnew, skid_tnew, head_d_tnew;

  assign out_valid = (state_q != ST_EMPTY);

  // With a skid entry In_Ready comes straight from the state flops, breaking the Out_Ready->In_Ready path.
  always_comb begin
    if (SKID) in_ready = (state_q != ST_TWO);
    else      in_ready = (~out_valid | Out_Ready) & ~Flush;
  end

  assign push = In_Valid & in_ready;
  assign pop  = out_valid & Out_Ready;

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_clear     = 1'b0;
    head_hold      = out_valid;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    skid_hold      = (state_q == ST_TWO);
    if (Flush) begin
      state_d    = ST_EMPTY;
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) begin
          state_d   = ST_ONE;
          head_load = 1'b1;
        end
        ST_ONE: begin
          if (push && pop) begin
            head_load = 1'b1;
          end else if (push && SKID) begin
            state_d   = ST_TWO;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d    = ST_EMPTY;
            head_clear = 1'b1;
          end
        end
        ST_TWO: if (pop) begin
          state_d        = ST_ONE;
          head_load      = 1'b1;
          head_from_skid = 1'b1;
          skid_clear     = 1'b1;
        end
        default: begin
          state_d    = ST_EMPTY;
          head_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  assign head_d_payload  = head_from_skid ? skid_payload  : In_Payload;
  assign head_d_reg_addr = head_from_skid ? skid_reg_addr : In_RegAddr;
  assign head_d_tnew     = head_from_skid ? skid_tnew     : In_Tnew;

  pipe_slot #(.PAYLOAD_W(PAYLOAD_W), .ADDR_W(ADDR_W), .TNEW_W(TNEW_W)) u_head (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .load       (head_load),
    .clear      (head_clear),
    .hold_dec   (head_hold),
    .d_payload  (head_d_payload),
    .d_reg_addr (head_d_reg_addr),
    .d_tnew     (head_d_tnew),
    .q_payload  (head_payload),
    .q_reg_addr (head_reg_addr),
    .q_tnew     (head_tnew)
  );

  if (SKID) begin : g_skid
    pipe_slot #(.PAYLOAD_W(PAYLOAD_W), .ADDR_W(ADDR_W), .TNEW_W(TNEW_W)) u_skid (
      .clk        (Clk),
      .rst_n      (Reset_n),
      .load       (skid_load),
      .clear      (skid_clear),
      .hold_dec   (skid_hold),
      .d_payload  (In_Payload),
      .d_reg_addr (In_RegAddr),
      .d_tnew     (In_Tnew),
      .q_payload  (skid_payload),
      .q_reg_addr (skid_reg_addr),
      .q_tnew     (skid_tnew)
    );
  end else begin : g_no_skid
    assign skid_payload  = '0;
    assign skid_reg_addr = '0;
    assign skid_tnew     = '0;
  end

  assign In_Ready    = in_ready;
  assign Out_Valid   = out_valid;
  assign Out_Payload = out_valid ? head_payload  : '0;
  assign Out_RegAddr = out_valid ? head_reg_addr : '0;
  assign Out_Tnew    = out_valid ? head_tnew     : '0;
  assign Occupancy   = state_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: one SKID=1 and one SKID=0 instance, each tracked
// by a queue-based reference model of the stage's FIFO and Tnew rules.
module tb_pipe_skid_stage;

  localparam int PW    = 96;
  localparam int AW    = 5;
  localparam int TW    = 3;
  localparam int OBS_W = 1 + PW + AW + TW + 2;

  typedef struct packed {
    logic [PW-1:0] payload;
    logic [AW-1:0] addr;
    logic [TW-1:0] tnew;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
  logic [PW-1:0] s1_in_payload, s1_out_payload;
  logic [AW-1:0] s1_in_addr, s1_out_addr;
  logic [TW-1:0] s1_in_tnew, s1_out_tnew;
  logic [1:0]    s1_occ;

  logic          s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [PW-1:0] s0_in_payload, s0_out_payload;
  logic [AW-1:0] s0_in_addr, s0_out_addr;
  logic [TW-1:0] s0_in_tnew, s0_out_tnew;
  logic [1:0]    s0_occ;

  pipe_skid_stage #(.PAYLOAD_W(PW), .ADDR_W(AW), .TNEW_W(TW), .SKID(1'b1)) dut1 (
    .Clk(clk), .Reset_n(rst_n), .Flush(s1_flush),
    .In_Valid(s1_in_valid), .In_Ready(s1_in_ready), .In_Payload(s1_in_payload),
    .In_RegAddr(s1_in_addr), .In_Tnew(s1_in_tnew),
    .Out_Valid(s1_out_valid), .Out_Ready(s1_out_ready), .Out_Payload(s1_out_payload),
    .Out_RegAddr(s1_out_addr), .Out_Tnew(s1_out_tnew), .Occupancy(s1_occ)
  );

  pipe_skid_stage #(.PAYLOAD_W(PW), .ADDR_W(AW), .TNEW_W(TW), .SKID(1'b0)) dut0 (
    .Clk(clk), .Reset_n(rst_n), .Flush(s0_flush),
    .In_Valid(s0_in_valid), .In_Ready(s0_in_ready), .In_Payload(s0_in_payload),
    .In_RegAddr(s0_in_addr), .In_Tnew(s0_in_tnew),
    .Out_Valid(s0_out_valid), .Out_Ready(s0_out_ready), .Out_Payload(s0_out_payload),
    .Out_RegAddr(s0_out_addr), .Out_Tnew(s0_out_tnew), .Occupancy(s0_occ)
  );

  wire [OBS_W-1:0] obs1 = {s1_out_valid, s1_out_payload, s1_out_addr, s1_out_tnew, s1_occ};
  wire [OBS_W-1:0] obs0 = {s0_out_valid, s0_out_payload, s0_out_addr, s0_out_tnew, s0_occ};

  ent_t q1[$];
  ent_t q0[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [TW-1:0] dec(input logic [TW-1:0] t);
    return (t == 0) ? 3'd0 : t - 3'd1;
  endfunction

  function automatic logic [OBS_W-1:0] exp1();
    if (q1.size() == 0) return '0;
    return {1'b1, q1[0].payload, q1[0].addr, q1[0].tnew, 2'(q1.size())};
  endfunction

  function automatic logic [OBS_W-1:0] exp0();
    if (q0.size() == 0) return '0;
    return {1'b1, q0[0].payload, q0[0].addr, q0[0].tnew, 2'(q0.size())};
  endfunction

  function automatic logic exp_rdy1();
    return q1.size() < 2;
  endfunction

  function automatic logic exp_rdy0();
    return (q0.size() == 0 || s0_out_ready) && !s0_flush;
  endfunction

  task automatic drive1(input logic v, input logic [PW-1:0] p, input logic [AW-1:0] a,
                        input logic [TW-1:0] t, input logic rdy, input logic fl);
    s1_in_valid = v; s1_in_payload = p; s1_in_addr = a; s1_in_tnew = t;
    s1_out_ready = rdy; s1_flush = fl;
  endtask

  task automatic drive0(input logic v, input logic [PW-1:0] p, input logic [AW-1:0] a,
                        input logic [TW-1:0] t, input logic rdy, input logic fl);
    s0_in_valid = v; s0_in_payload = p; s0_in_addr = a; s0_in_tnew = t;
    s0_out_ready = rdy; s0_flush = fl;
  endtask

  // One clock edge: both models advance from the inputs held across the edge.
  task automatic cycle();
    logic push1, pop1, push0, pop0;
    ent_t e1, e0;
    push1 = s1_in_valid && exp_rdy1();
    pop1  = (q1.size() > 0) && s1_out_ready;
    push0 = s0_in_valid && exp_rdy0();
    pop0  = (q0.size() > 0) && s0_out_ready;
    e1 = {s1_in_payload, s1_in_addr, dec(s1_in_tnew)};
    e0 = {s0_in_payload, s0_in_addr, dec(s0_in_tnew)};
    @(posedge clk);
    if (s1_flush) q1.delete();
    else begin
      if (pop1) void'(q1.pop_front());
      foreach (q1[i]) q1[i].tnew = dec(q1[i].tnew);
      if (push1) q1.push_back(e1);
    end
    if (s0_flush) q0.delete();
    else begin
      if (pop0) void'(q0.pop_front());
      foreach (q0[i]) q0[i].tnew = dec(q0[i].tnew);
      if (push0) q0.push_back(e0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++;
    if (obs1 !== '0 || obs0 !== '0) begin
      n_errors++; $display("FAIL reset_state: got %h / %h expected all zero", obs1, obs0);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (s1_in_ready !== 1'b1 || s0_in_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_in_ready: got %b/%b expected 1/1", s1_in_ready, s0_in_ready);
    end
    drive1(1'b1, 96'hA1, 5'd3, 3'd2, 1'b0, 1'b0);
    drive0(1'b1, 96'hB1, 5'd4, 3'd2, 1'b0, 1'b0);
    cycle();
    drive1(1'b1, 96'hA2, 5'd5, 3'd2, 1'b0, 1'b0);
    drive0(1'b0, 96'h0, 5'd0, 3'd0, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if (s1_occ !== 2'd2 || obs1 !== exp1()) begin
      n_errors++; $display("FAIL reset_prefill: got %h expected %h", obs1, exp1());
    end
    drive1(1'b1, 96'hA3, 5'd6, 3'd1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs1 !== '0 || obs0 !== '0) begin
      n_errors++; $display("FAIL reset_async: got %h / %h expected all zero", obs1, obs0);
    end
    q1.delete();
    q0.delete();
    drive1(1'b0, 96'h0, 5'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (s1_in_ready !== 1'b1 || s0_in_ready !== 1'b1 || s1_occ !== 2'd0) begin
      n_errors++; $display("FAIL reset_release: got rdy %b/%b occ %0d expected 1/1 occ 0",
                           s1_in_ready, s0_in_ready, s1_occ);
    end
  endtask

  task automatic test_streaming();
    for (int k = 1; k <= 8; k++) begin
      drive1(1'b1, PW'(k), AW'(k), 3'd2, 1'b1, 1'b0);
      cycle();
      n_checks++;
      if (obs1 !== exp1()) begin
        n_errors++; $display("FAIL stream_model[%0d]: got %h expected %h", k, obs1, exp1());
      end
      n_checks++;
      if (s1_out_valid !== 1'b1 || s1_out_payload !== PW'(k) || s1_out_tnew !== 3'd1) begin
        n_errors++; $display("FAIL stream_value[%0d]: got v=%b p=%0h t=%0d expected v=1 p=%0h t=1",
                             k, s1_out_valid, s1_out_payload, s1_out_tnew, k);
      end
    end
    drive1(1'b0, 96'h0, 5'd0, 3'd0, 1'b1, 1'b0);
    cycle();
    n_checks++;
    if (s1_out_valid !== 1'b0 || s1_out_payload !== '0 || obs1 !== exp1()) begin
      n_errors++; $display("FAIL stream_drain: got %h expected %h", obs1, exp1());
    end
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] tn_exp [4] = '{3'd2, 3'd1, 3'd0, 3'd0};
    for (int c = 0; c < 4; c++) begin
      if (c < 2) drive1(1'b1, (c == 0) ? 96'hAAAA : 96'hBBBB, AW'(c + 1), 3'd3, 1'b0, 1'b0);
      else       drive1(1'b0, 96'h0, 5'd0, 3'd0, 1'b0, 1'b0);
      cycle();
      n_checks++;
      if (obs1 !== exp1() || s1_out_tnew !== tn_exp[c] || s1_out_payload !== 96'hAAAA ||
          s1_occ !== ((c == 0) ? 2'd1 : 2'd2) || s1_in_ready !== (c == 0)) begin
        n_errors++; $display("FAIL bp_stall[%0d]: got %h rdy %b expected %h tnew %0d",
                             c, obs1, s1_in_ready, exp1(), tn_exp[c]);
      end
    end
    drive1(1'b0, 96'h0, 5'd0, 3'd0, 1'b1, 1'b0);
    cycle();
    n_checks++;
    if (obs1 !== exp1() || s1_out_payload !== 96'hBBBB || s1_occ !== 2'd1) begin
      n_errors++; $display("FAIL bp_second: got %h expected %h", obs1, exp1());
    end
    cycle();
    n_checks++;
    if (s1_out_valid !== 1'b0 || obs1 !== exp1()) begin
      n_errors++; $display("FAIL bp_empty: got %h expected %h", obs1, exp1());
    end
  endtask

  task automatic test_flush();
    drive1(1'b1, 96'hC1, 5'd7, 3'd4, 1'b0, 1'b0);
    cycle();
    drive1(1'b1, 96'hC2, 5'd8, 3'd4, 1'b0, 1'b0);
    cycle();
    drive1(1'b1, 96'hC3, 5'd9, 3'd4, 1'b1, 1'b1);
    drive0(1'b1, 96'hD1, 5'd9, 3'd4, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if (s1_out_valid !== 1'b0 || s1_occ !== 2'd0 || s1_out_payload !== '0 || s1_out_addr !== '0) begin
      n_errors++; $display("FAIL flush_skid1: got %h expected all zero", obs1);
    end
    drive1(1'b0, 96'h0, 5'd0, 3'd0, 1'b0, 1'b0);
    drive0(1'b1, 96'hD2, 5'd10, 3'd4, 1'b1, 1'b1);
    #1;
    n_checks++;
    if (s0_in_ready !== 1'b0) begin
      n_errors++; $display("FAIL flush_skid0_ready: got %b expected 0", s0_in_ready);
    end
    cycle();
    n_checks++;
    if (obs0 !== '0 || obs0 !== exp0()) begin
      n_errors++; $display("FAIL flush_skid0: got %h expected all zero", obs0);
    end
    drive0(1'b0, 96'h0, 5'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_skid0();
    drive0(1'b1, 96'hE1, 5'd11, 3'd1, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if (s0_occ !== 2'd1 || s0_out_payload !== 96'hE1 || obs0 !== exp0()) begin
      n_errors++; $display("FAIL skid0_fill: got %h expected %h", obs0, exp0());
    end
    drive0(1'b1, 96'hE2, 5'd12, 3'd3, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (s0_in_ready !== 1'b0) begin
      n_errors++; $display("FAIL skid0_stall_ready: got %b expected 0", s0_in_ready);
    end
    cycle();
    n_checks++;
    if (s0_out_payload !== 96'hE1 || s0_occ !== 2'd1 || obs0 !== exp0()) begin
      n_errors++; $display("FAIL skid0_hold: got %h expected %h", obs0, exp0());
    end
    drive0(1'b1, 96'hE3, 5'd13, 3'd3, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (s0_in_ready !== 1'b1) begin
      n_errors++; $display("FAIL skid0_same_cycle_ready: got %b expected 1", s0_in_ready);
    end
    cycle();
    n_checks++;
    if (s0_out_payload !== 96'hE3 || s0_occ !== 2'd1 || s0_out_tnew !== 3'd2 || obs0 !== exp0()) begin
      n_errors++; $display("FAIL skid0_replace: got %h expected %h", obs0, exp0());
    end
    drive0(1'b0, 96'h0, 5'd0, 3'd0, 1'b1, 1'b0);
    cycle();
  endtask

  task automatic test_tnew_sat();
    drive1(1'b1, 96'hF00D, 5'd14, 3'd0, 1'b0, 1'b0);
    cycle();
    drive1(1'b0, 96'h0, 5'd0, 3'd0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      cycle();
      n_checks++;
      if (s1_out_tnew !== 3'd0 || s1_out_payload !== 96'hF00D || s1_out_addr !== 5'd14 ||
          obs1 !== exp1()) begin
        n_errors++; $display("FAIL tnew_sat[%0d]: got %h expected %h", c, obs1, exp1());
      end
    end
    drive1(1'b0, 96'h0, 5'd0, 3'd0, 1'b1, 1'b0);
    cycle();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      drive1($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom}, AW'($urandom), TW'($urandom),
             $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      drive0($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom}, AW'($urandom), TW'($urandom),
             $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      #1;
      n_checks++;
      if (s1_in_ready !== exp_rdy1() || s0_in_ready !== exp_rdy0()) begin
        n_errors++; bad++;
        if (bad < 10) $display("FAIL rand_ready[%0d]: got %b/%b expected %b/%b",
                               c, s1_in_ready, s0_in_ready, exp_rdy1(), exp_rdy0());
      end
      cycle();
      n_checks++;
      if (obs1 !== exp1()) begin
        n_errors++; bad++;
        if (bad < 10) $display("FAIL rand_skid1[%0d]: got %h expected %h", c, obs1, exp1());
      end
      n_checks++;
      if (obs0 !== exp0()) begin
        n_errors++; bad++;
        if (bad < 10) $display("FAIL rand_skid0[%0d]: got %h expected %h", c, obs0, exp0());
      end
    end
  endtask

  initial begin
    drive1(1'b0, 96'h0, 5'd0, 3'd0, 1'b0, 1'b0);
    drive0(1'b0, 96'h0, 5'd0, 3'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_skid0();
    test_tnew_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
